moore_event_recorder: RTL and testbench

MOORE_EVENT_RECORDER -- requirements
Module: moore_event_recorder

---
 rtl/moore_evt_pkg.sv | 9 +
 rtl/evt_fifo.sv | 64 ++++++
 rtl/moore_event_recorder.sv | 83 ++++++++
 tb/tb_moore_event_recorder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_evt_pkg.sv
// Shared defaults and types for the Moore-output event recorder.
// Keep these in step with the defaults of the modules that import the package.
package moore_evt_pkg;
  localparam int TS_W_DEF  = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef logic [TS_W_DEF-1:0] ts_t;
endpackage

// File: rtl/evt_fifo.sv
// Small FIFO of timestamps. Pointers carry one extra wrap bit so that full and empty can be told apart.
// DEPTH must be a power of two and at least 2.
module evt_fifo
  import moore_evt_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_b,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage is not reset, so the head is masked to zero whenever nothing is stored.
  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/moore_event_recorder.sv
// Timestamps rising edges of a Moore detector output and queues them for a consumer.
// Also keeps a saturating event count and a sticky overflow flag for dropped events.
module moore_event_recorder
  import moore_evt_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RST_b,
  input  logic                   y_out,
  input  logic                   clr_i,
  input  logic                   ev_ready_i,
  output logic                   ev_valid_o,
  output logic [TS_W-1:0]        ev_ts_o,
  output logic [$clog2(DEPTH):0] ev_level_o,
  output logic [CNT_W-1:0]       ev_count_o,
  output logic                   ovf_o
);
  // Handshake: an entry leaves the FIFO on every posedge where ev_valid_o and
  // ev_ready_i are both 1; ev_valid_o/ev_ts_o never depend on ev_ready_i and
  // hold steady until that transfer.

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             y_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             event_w;
  logic             pop_w;
  logic             full_w;
  logic             empty_w;

  assign event_w    = y_out & ~y_prev_q;
  assign ev_valid_o = ~empty_w;
  assign pop_w      = ev_valid_o & ev_ready_i;
  assign ev_count_o = cnt_q;
  assign ovf_o      = ovf_q;
  assign ts_d       = ts_q + 1'b1;

  evt_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_b   (RST_b),
    .push_i  (event_w),
    .pop_i   (pop_w),
    .clr_i   (clr_i),
    .data_i  (ts_q),
    .full_o  (full_w),
    .empty_o (empty_w),
    .level_o (ev_level_o),
    .head_o  (ev_ts_o)
  );

  // Clear wins over a same-cycle event: nothing is counted or flagged.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (event_w) begin
      if (cnt_q != '1)       cnt_d = cnt_q + 1'b1;
      if (full_w && !pop_w)  ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      ts_q     <= '0;
      y_prev_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      y_prev_q <= y_out;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_moore_event_recorder.sv
// Directed bench for moore_event_recorder: inputs change and outputs are read on the falling edge.
module tb_moore_event_recorder;
  logic       CLK = 1'b0;
  logic       RST_b;
  logic       y_out;
  logic       clr_i;
  logic       ev_ready_i;
  logic       ev_valid_o;
  logic [7:0] ev_ts_o;
  logic [2:0] ev_level_o;
  logic [7:0] ev_count_o;
  logic       ovf_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] tb_ts;

  always #5 CLK = ~CLK;

  moore_event_recorder dut (
    .CLK        (CLK),
    .RST_b      (RST_b),
    .y_out      (y_out),
    .clr_i      (clr_i),
    .ev_ready_i (ev_ready_i),
    .ev_valid_o (ev_valid_o),
    .ev_ts_o    (ev_ts_o),
    .ev_level_o (ev_level_o),
    .ev_count_o (ev_count_o),
    .ovf_o      (ovf_o)
  );

  // tb_ts is the timestamp the DUT holds in the current cycle.
  task automatic tick();
    @(negedge CLK);
    tb_ts = tb_ts + 8'd1;
  endtask

  task automatic wait_ts(input logic [7:0] t);
    while (tb_ts != t) tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_b = 1'b0; y_out = 1'b0; clr_i = 1'b0; ev_ready_i = 1'b0;
    @(negedge CLK);
    RST_b = 1'b1;
    tb_ts = 8'd0;
  endtask

  task automatic pulse_at(input logic [7:0] t);
    wait_ts(t);
    y_out = 1'b1;
    tick();
    y_out = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_b = 1'b0; y_out = 1'b0; clr_i = 1'b0; ev_ready_i = 1'b0;
    #1;
    n_checks++;
    if ({ev_valid_o, ev_ts_o, ev_level_o, ev_count_o, ovf_o} !== 21'd0)
      $display("FAIL reset_outputs: got v=%0b ts=%0d lvl=%0d cnt=%0d ovf=%0b, expected all 0",
               ev_valid_o, ev_ts_o, ev_level_o, ev_count_o, ovf_o);
    else n_pass++;
    @(negedge CLK);
    RST_b = 1'b1;
    tb_ts = 8'd0;
  endtask

  task automatic test_single_event();
    do_reset();
    wait_ts(8'd5);
    y_out = 1'b1;
    tick();
    n_checks++;
    if ({ev_valid_o, ev_ts_o, ev_level_o, ev_count_o} !== {1'b1, 8'd5, 3'd1, 8'd1})
      $display("FAIL single_first: got v=%0b ts=%0d lvl=%0d cnt=%0d, expected v=1 ts=5 lvl=1 cnt=1",
               ev_valid_o, ev_ts_o, ev_level_o, ev_count_o);
    else n_pass++;
    tick();
    tick();
    y_out = 1'b0;
    tick();
    n_checks++;
    if ({ev_ts_o, ev_level_o, ev_count_o} !== {8'd5, 3'd1, 8'd1})
      $display("FAIL single_held: got ts=%0d lvl=%0d cnt=%0d, expected ts=5 lvl=1 cnt=1",
               ev_ts_o, ev_level_o, ev_count_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ts [4];
    exp_ts = '{8'd10, 8'd12, 8'd14, 8'd16};
    do_reset();
    for (int i = 0; i < 5; i++) pulse_at(8'(10 + 2*i));
    n_checks++;
    if ({ev_level_o, ovf_o, ev_count_o, ev_ts_o} !== {3'd4, 1'b1, 8'd5, 8'd10})
      $display("FAIL ovf_state: got lvl=%0d ovf=%0b cnt=%0d ts=%0d, expected lvl=4 ovf=1 cnt=5 ts=10",
               ev_level_o, ovf_o, ev_count_o, ev_ts_o);
    else n_pass++;
    ev_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_valid_o !== 1'b1 || ev_ts_o !== exp_ts[i] || ev_level_o !== 3'(4 - i))
        $display("FAIL ovf_drain%0d: got v=%0b ts=%0d lvl=%0d, expected v=1 ts=%0d lvl=%0d",
                 i, ev_valid_o, ev_ts_o, ev_level_o, exp_ts[i], 4 - i);
      else n_pass++;
      tick();
    end
    ev_ready_i = 1'b0;
    n_checks++;
    if (ev_valid_o !== 1'b0 || ovf_o !== 1'b1)
      $display("FAIL ovf_empty: got v=%0b ovf=%0b, expected v=0 ovf=1", ev_valid_o, ovf_o);
    else n_pass++;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n_checks++;
    if (ovf_o !== 1'b0 || ev_count_o !== 8'd0)
      $display("FAIL ovf_clear: got ovf=%0b cnt=%0d, expected ovf=0 cnt=0", ovf_o, ev_count_o);
    else n_pass++;
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_ts [4];
    exp_ts = '{8'd4, 8'd6, 8'd8, 8'd10};
    do_reset();
    for (int i = 1; i <= 4; i++) pulse_at(8'(2*i));
    wait_ts(8'd10);
    y_out = 1'b1;
    ev_ready_i = 1'b1;
    tick();
    y_out = 1'b0;
    ev_ready_i = 1'b0;
    n_checks++;
    if ({ev_level_o, ovf_o, ev_count_o} !== {3'd4, 1'b0, 8'd5})
      $display("FAIL fullpp_state: got lvl=%0d ovf=%0b cnt=%0d, expected lvl=4 ovf=0 cnt=5",
               ev_level_o, ovf_o, ev_count_o);
    else n_pass++;
    ev_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_valid_o !== 1'b1 || ev_ts_o !== exp_ts[i])
        $display("FAIL fullpp_drain%0d: got v=%0b ts=%0d, expected v=1 ts=%0d",
                 i, ev_valid_o, ev_ts_o, exp_ts[i]);
      else n_pass++;
      tick();
    end
    ev_ready_i = 1'b0;
  endtask

  task automatic test_clear_priority();
    do_reset();
    pulse_at(8'd2);
    pulse_at(8'd4);
    n_checks++;
    if (ev_level_o !== 3'd2 || ev_count_o !== 8'd2)
      $display("FAIL clr_setup: got lvl=%0d cnt=%0d, expected lvl=2 cnt=2", ev_level_o, ev_count_o);
    else n_pass++;
    wait_ts(8'd6);
    y_out = 1'b1; clr_i = 1'b1; ev_ready_i = 1'b1;
    tick();
    y_out = 1'b0; clr_i = 1'b0; ev_ready_i = 1'b0;
    n_checks++;
    if ({ev_valid_o, ev_level_o, ev_count_o, ovf_o} !== {1'b0, 3'd0, 8'd0, 1'b0})
      $display("FAIL clr_priority: got v=%0b lvl=%0d cnt=%0d ovf=%0b, expected all 0",
               ev_valid_o, ev_level_o, ev_count_o, ovf_o);
    else n_pass++;
    // The timestamp keeps running through a clear.
    pulse_at(8'd9);
    n_checks++;
    if (ev_ts_o !== 8'd9 || ev_level_o !== 3'd1)
      $display("FAIL clr_ts_kept: got ts=%0d lvl=%0d, expected ts=9 lvl=1", ev_ts_o, ev_level_o);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    ev_ready_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      y_out = 1'b1;
      tick();
      y_out = 1'b0;
      n_checks++;
      if (ev_valid_o !== 1'b1 || ev_ts_o !== 8'(2*k))
        $display("FAIL sat_ts%0d: got v=%0b ts=%0d, expected v=1 ts=%0d",
                 k, ev_valid_o, ev_ts_o, 8'(2*k));
      else n_pass++;
      tick();
    end
    ev_ready_i = 1'b0;
    n_checks++;
    if (ev_count_o !== 8'd255 || ev_level_o !== 3'd0 || ovf_o !== 1'b0)
      $display("FAIL sat_count: got cnt=%0d lvl=%0d ovf=%0b, expected cnt=255 lvl=0 ovf=0",
               ev_count_o, ev_level_o, ovf_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_at(8'd1);
    pulse_at(8'd3);
    pulse_at(8'd5);
    n_checks++;
    if (ev_level_o !== 3'd3)
      $display("FAIL rstmid_setup: got lvl=%0d, expected 3", ev_level_o);
    else n_pass++;
    #2;
    RST_b = 1'b0;
    #1;
    n_checks++;
    if ({ev_valid_o, ev_ts_o, ev_level_o, ev_count_o, ovf_o} !== 21'd0)
      $display("FAIL rstmid_outputs: got v=%0b ts=%0d lvl=%0d cnt=%0d ovf=%0b, expected all 0",
               ev_valid_o, ev_ts_o, ev_level_o, ev_count_o, ovf_o);
    else n_pass++;
    y_out = 1'b1;
    @(negedge CLK);
    RST_b = 1'b1;
    tb_ts = 8'd0;
    n_checks++;
    if (ev_level_o !== 3'd0)
      $display("FAIL rstmid_release: got lvl=%0d, expected 0", ev_level_o);
    else n_pass++;
    // y_out already high in the first cycle after release still counts as an edge.
    tick();
    y_out = 1'b0;
    n_checks++;
    if ({ev_valid_o, ev_ts_o, ev_level_o, ev_count_o} !== {1'b1, 8'd0, 3'd1, 8'd1})
      $display("FAIL rstmid_first_event: got v=%0b ts=%0d lvl=%0d cnt=%0d, expected v=1 ts=0 lvl=1 cnt=1",
               ev_valid_o, ev_ts_o, ev_level_o, ev_count_o);
    else n_pass++;
  endtask

  initial begin
    RST_b = 1'b1; y_out = 1'b0; clr_i = 1'b0; ev_ready_i = 1'b0; tb_ts = 8'd0;
    test_reset();
    test_single_event();
    test_overflow();
    test_full_pop_push();
    test_clear_priority();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
